arbitro_memoria: RTL and testbench
==================================

# arbitro_memoria

Sequencer and arbiter for the 16×16-bit register bank (`memoria`). It shares the bank's write port and read port 1 between two requesters:
- the CPU execute/write-back path;
- the LCD display scanner that reads registers for exhibition.

It also owns the bank-clear sweep, which writes zero to every address one per cycle. The sweep replaces the single-cycle clear flag. The block sits between the CPU FSM / LCD FSM and `banco_memoria`.

## Interface
- No parameters. Bank geometry is fixed at 16 addresses × 16 bits.
- `clk  in  1`  system clock; all state updates on rising edge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `iniciar_clear  in  1`  one-cycle pulse; requests a full bank clear sweep.
- `cpu_req  in  1`  CPU access request; held until `cpu_gnt`.
- `cpu_escrever  in  1`  1 = write, 0 = read.
- `cpu_endereco_escrita  in  4`  CPU write address.
- `cpu_dado  in  16`  CPU write data.
- `cpu_endereco_leitura  in  4`  CPU read address.
- `cpu_gnt  out  1`  CPU grant; the access happens in this cycle.
- `cpu_dado_lido  out  16`  registered read data.
- `cpu_valido  out  1`  one-cycle pulse; `cpu_dado_lido` is valid.
- `lcd_req  in  1`  LCD read request; held until `lcd_gnt`.
- `lcd_endereco  in  4`  LCD read address.
- `lcd_gnt  out  1`  LCD grant.
- `lcd_dado_lido  out  16`  registered read data.
- `lcd_valido  out  1`  one-cycle pulse.
- `mem_enable  out  1`  bank write enable.
- `mem_endereco_escrita  out  4`  bank write address.
- `mem_conteudo_escrita  out  16`  bank write data.
- `mem_endereco_leitura  out  4`  bank read-port-1 address.
- `mem_conteudo_leitura  in  16`  bank read-port-1 data (combinational read).
- `ocupado  out  1`  high while a clear sweep is running.

## Operation
- States:
  - OCIOSO: no grant.
  - CONCEDE_CPU: `cpu_gnt`=1.
  - CONCEDE_LCD: `lcd_gnt`=1.
  - LIMPANDO: clear sweep.
- Next-state decision is evaluated every cycle from the current inputs, in this priority order:
  1. Clear pending → LIMPANDO.
  2. Exactly one requester active → that requester.
  3. Both active → the one not recorded in `ultimo` (round-robin). `ultimo` updates on every completed grant.
  4. Neither active → OCIOSO.
- Clear pending: a clear is pending when `iniciar_clear` is seen, or was latched by a flag during a grant cycle.
- Grant cycle:
  - The mux drives the bank from the granted requester's current inputs.
  - The transaction is effective only if that requester's req is still high in the grant cycle. Otherwise it is a wasted cycle: no write, no valid pulse.
- CPU write:
  - `mem_enable`=`cpu_gnt`&`cpu_req`&`cpu_escrever`.
  - Write address and data come from `cpu_endereco_escrita` / `cpu_dado`.
- Read (CPU with `cpu_escrever`=0, or LCD):
  - `mem_endereco_leitura`=requester address.
  - `mem_conteudo_leitura` is captured into `*_dado_lido` at the grant cycle's closing edge.
  - `*_valido`=1 for the following cycle only.
- LIMPANDO:
  - 4-bit counter `cont` runs 0..15.
  - Each cycle: `mem_enable`=1, `mem_endereco_escrita`=`cont`, `mem_conteudo_escrita`=0.
  - After address 15 → decision logic (back to arbitration).
  - `ocupado`=1 for all 16 cycles.
- Defaults when not driven: `mem_enable`=0, addresses=0, write data=0.

## Timing
- Reset (async, while `rst_n`=0):
  - state=OCIOSO, `cont`=0, `ultimo`=LCD (so CPU wins the first tie), clear flag=0.
  - Every output=0, including `*_dado_lido`.
- Grant latency:
  - req high at edge E → gnt high in the cycle after E. Minimum 1 cycle; no combinational req→gnt path.
  - Read data and valid appear 1 cycle after the grant cycle.
- Back-to-back grants:
  - If a req stays high through its grant cycle, it is a new request at that edge.
  - A single requester can be granted every cycle.
  - With both requesters continuously active, grants alternate CPU, LCD, CPU…
- `iniciar_clear` timing:
  - Arriving during a grant cycle: the grant completes, then LIMPANDO starts the next cycle.
  - Arriving during LIMPANDO: ignored; the sweep neither restarts nor extends.
- Requests during LIMPANDO wait. Maximum wait from `iniciar_clear` = 17 cycles + the arbitration cycle.
- `cpu_gnt` and `lcd_gnt` are mutually exclusive and never asserted in LIMPANDO.
- `rst_n` low mid-sweep or mid-grant: immediate abort. The partial clear is not resumed, and any pending valid is dropped.

## Test plan
- Reset: hold `rst_n`=0 with all reqs high → all outputs 0. Release → first grant goes to CPU (tie, `ultimo`=LCD).
- CPU write then read: write 16'hBEEF to addr 5 (1 cycle after req, `mem_enable`=1, addr 5). Then read addr 5 with `mem_conteudo_leitura` model → `cpu_dado_lido`=16'hBEEF, `cpu_valido` 1 cycle after grant.
- Contention: `cpu_req` and `lcd_req` both held high for 6 cycles → grant sequence CPU, LCD, CPU, LCD, CPU; never both high.
- Clear sweep: pulse `iniciar_clear` → 16 consecutive cycles of `mem_enable`=1, addresses 0..15, data 0, `ocupado`=1. A `lcd_req` raised in sweep cycle 3 is granted the cycle after address 15.
- Clear during grant: `iniciar_clear` in a CPU grant cycle → CPU write completes, sweep starts next cycle. A second `iniciar_clear` at sweep cycle 8 → still exactly 16 cycles.
- Dropped req and reset: `lcd_req` deasserted in its grant cycle → no `lcd_valido`. Separately, `rst_n`=0 at sweep address 7 → `mem_enable` drops immediately, state OCIOSO after release.

Source files
------------

// File: rtl/arbitro_memoria.sv
// Arbiter/sequencer for the 16x16 register bank: shares the write port and read port 1
// between the CPU and the LCD scanner, and runs the one-address-per-cycle clear sweep.
module arbitro_memoria (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iniciar_clear,
    input  logic        cpu_req,
    input  logic        cpu_escrever,
    input  logic [3:0]  cpu_endereco_escrita,
    input  logic [15:0] cpu_dado,
    input  logic [3:0]  cpu_endereco_leitura,
    output logic        cpu_gnt,
    output logic [15:0] cpu_dado_lido,
    output logic        cpu_valido,
    input  logic        lcd_req,
    input  logic [3:0]  lcd_endereco,
    output logic        lcd_gnt,
    output logic [15:0] lcd_dado_lido,
    output logic        lcd_valido,
    output logic        mem_enable,
    output logic [3:0]  mem_endereco_escrita,
    output logic [15:0] mem_conteudo_escrita,
    output logic [3:0]  mem_endereco_leitura,
    input  logic [15:0] mem_conteudo_leitura,
    output logic        ocupado
);

    // estado      | meaning
    // OCIOSO      | no grant this cycle
    // CONCEDE_CPU | CPU owns the bank ports this cycle
    // CONCEDE_LCD | LCD owns read port 1 this cycle
    // LIMPANDO    | clear sweep, writing zero to address cont_q
    typedef enum logic [1:0] {OCIOSO, CONCEDE_CPU, CONCEDE_LCD, LIMPANDO} estado_t;

    estado_t     estado_q, estado_d, proximo;
    logic [3:0]  cont_q, cont_d;
    logic        ultimo_q, ultimo_d;        // 1 = CPU was granted last
    logic        clear_flag_q, clear_flag_d;
    logic        clear_pend;
    logic        cpu_valido_q, cpu_valido_d;
    logic        lcd_valido_q, lcd_valido_d;
    logic [15:0] cpu_dado_q, cpu_dado_d;
    logic [15:0] lcd_dado_q, lcd_dado_d;

    always_comb begin
        // the current grant counts as "last" so back-to-back ties alternate
        ultimo_d = ultimo_q;
        if (estado_q == CONCEDE_CPU)
            ultimo_d = 1'b1;
        else if (estado_q == CONCEDE_LCD)
            ultimo_d = 1'b0;

        clear_pend = (estado_q != LIMPANDO) && (iniciar_clear || clear_flag_q);

        if (clear_pend)
            proximo = LIMPANDO;
        else if (cpu_req && lcd_req)
            proximo = ultimo_d ? CONCEDE_LCD : CONCEDE_CPU;
        else if (cpu_req)
            proximo = CONCEDE_CPU;
        else if (lcd_req)
            proximo = CONCEDE_LCD;
        else
            proximo = OCIOSO;

        if (estado_q == LIMPANDO && cont_q != 4'd15)
            estado_d = LIMPANDO;
        else
            estado_d = proximo;

        cont_d       = (estado_q == LIMPANDO) ? cont_q + 4'd1 : 4'd0;
        clear_flag_d = clear_pend && (estado_d != LIMPANDO);

        cpu_valido_d = (estado_q == CONCEDE_CPU) && cpu_req && !cpu_escrever;
        lcd_valido_d = (estado_q == CONCEDE_LCD) && lcd_req;
        cpu_dado_d   = cpu_valido_d ? mem_conteudo_leitura : cpu_dado_q;
        lcd_dado_d   = lcd_valido_d ? mem_conteudo_leitura : lcd_dado_q;
    end

    always_comb begin
        cpu_gnt              = (estado_q == CONCEDE_CPU);
        lcd_gnt              = (estado_q == CONCEDE_LCD);
        ocupado              = (estado_q == LIMPANDO);
        mem_enable           = 1'b0;
        mem_endereco_escrita = 4'd0;
        mem_conteudo_escrita = 16'd0;
        mem_endereco_leitura = 4'd0;
        case (estado_q)
            CONCEDE_CPU: begin
                mem_endereco_leitura = cpu_endereco_leitura;
                if (cpu_req && cpu_escrever) begin
                    mem_enable           = 1'b1;
                    mem_endereco_escrita = cpu_endereco_escrita;
                    mem_conteudo_escrita = cpu_dado;
                end
            end
            CONCEDE_LCD: mem_endereco_leitura = lcd_endereco;
            LIMPANDO: begin
                mem_enable           = 1'b1;
                mem_endereco_escrita = cont_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            cont_q       <= 4'd0;
            ultimo_q     <= 1'b0;
            clear_flag_q <= 1'b0;
            cpu_valido_q <= 1'b0;
            lcd_valido_q <= 1'b0;
            cpu_dado_q   <= 16'd0;
            lcd_dado_q   <= 16'd0;
        end else begin
            estado_q     <= estado_d;
            cont_q       <= cont_d;
            ultimo_q     <= ultimo_d;
            clear_flag_q <= clear_flag_d;
            cpu_valido_q <= cpu_valido_d;
            lcd_valido_q <= lcd_valido_d;
            cpu_dado_q   <= cpu_dado_d;
            lcd_dado_q   <= lcd_dado_d;
        end
    end

    assign cpu_valido    = cpu_valido_q;
    assign lcd_valido    = lcd_valido_q;
    assign cpu_dado_lido = cpu_dado_q;
    assign lcd_dado_lido = lcd_dado_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: bank model, ownership-level reference model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_arbitro_memoria;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iniciar_clear = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_escrever = 1'b0;
    logic [3:0]  cpu_endereco_escrita = 4'd0;
    logic [15:0] cpu_dado = 16'd0;
    logic [3:0]  cpu_endereco_leitura = 4'd0;
    logic        cpu_gnt;
    logic [15:0] cpu_dado_lido;
    logic        cpu_valido;
    logic        lcd_req = 1'b0;
    logic [3:0]  lcd_endereco = 4'd0;
    logic        lcd_gnt;
    logic [15:0] lcd_dado_lido;
    logic        lcd_valido;
    logic        mem_enable;
    logic [3:0]  mem_endereco_escrita;
    logic [15:0] mem_conteudo_escrita;
    logic [3:0]  mem_endereco_leitura;
    logic [15:0] mem_conteudo_leitura;
    logic        ocupado;

    int n_tests = 0;
    int n_fail  = 0;

    arbitro_memoria dut (
        .clk(clk), .rst_n(rst_n), .iniciar_clear(iniciar_clear),
        .cpu_req(cpu_req), .cpu_escrever(cpu_escrever),
        .cpu_endereco_escrita(cpu_endereco_escrita), .cpu_dado(cpu_dado),
        .cpu_endereco_leitura(cpu_endereco_leitura), .cpu_gnt(cpu_gnt),
        .cpu_dado_lido(cpu_dado_lido), .cpu_valido(cpu_valido),
        .lcd_req(lcd_req), .lcd_endereco(lcd_endereco), .lcd_gnt(lcd_gnt),
        .lcd_dado_lido(lcd_dado_lido), .lcd_valido(lcd_valido),
        .mem_enable(mem_enable), .mem_endereco_escrita(mem_endereco_escrita),
        .mem_conteudo_escrita(mem_conteudo_escrita),
        .mem_endereco_leitura(mem_endereco_leitura),
        .mem_conteudo_leitura(mem_conteudo_leitura), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    // Register bank: preloaded with a recognisable pattern while reset is held.
    logic [15:0] bank [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) bank[i] <= 16'hA000 + 16'(i);
        end else if (mem_enable) begin
            bank[mem_endereco_escrita] <= mem_conteudo_escrita;
        end
    end
    assign mem_conteudo_leitura = bank[mem_endereco_leitura];

    task automatic chk(input string nome, input logic [15:0] atual, input logic [15:0] esperado);
        n_tests++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Reference model: who owns the bank this cycle (0 none, 1 cpu, 2 lcd, 3 sweep).
    int          m_owner;
    int          m_idx;
    logic        m_last_cpu;
    logic        m_cpu_v, m_lcd_v;
    logic [15:0] m_cpu_d, m_lcd_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_idx = 0; m_last_cpu = 1'b0;
            m_cpu_v = 1'b0; m_lcd_v = 1'b0; m_cpu_d = 16'd0; m_lcd_d = 16'd0;
        end else begin
            m_cpu_v = (m_owner == 1) && cpu_req && !cpu_escrever;
            m_lcd_v = (m_owner == 2) && lcd_req;
            if (m_cpu_v) m_cpu_d = bank[cpu_endereco_leitura];
            if (m_lcd_v) m_lcd_d = bank[lcd_endereco];
            if (m_owner == 3 && m_idx < 15) begin
                m_idx = m_idx + 1;
            end else begin
                if (m_owner == 1) m_last_cpu = 1'b1;
                if (m_owner == 2) m_last_cpu = 1'b0;
                if (iniciar_clear && m_owner != 3) begin
                    m_owner = 3; m_idx = 0;
                end else if (cpu_req && lcd_req) m_owner = m_last_cpu ? 2 : 1;
                else if (cpu_req) m_owner = 1;
                else if (lcd_req) m_owner = 2;
                else m_owner = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_en;
        logic [3:0]  e_wa;
        logic [15:0] e_wd;
        e_en = (m_owner == 3) || (m_owner == 1 && cpu_req && cpu_escrever);
        e_wa = (m_owner == 3) ? 4'(m_idx) : (e_en ? cpu_endereco_escrita : 4'd0);
        e_wd = (m_owner == 1 && e_en) ? cpu_dado : 16'd0;
        chk("m_cpu_gnt", 16'(cpu_gnt), 16'(m_owner == 1));
        chk("m_lcd_gnt", 16'(lcd_gnt), 16'(m_owner == 2));
        chk("m_ocupado", 16'(ocupado), 16'(m_owner == 3));
        chk("m_mem_enable", 16'(mem_enable), 16'(e_en));
        chk("m_waddr", 16'(mem_endereco_escrita), 16'(e_wa));
        chk("m_wdata", mem_conteudo_escrita, e_wd);
        if (m_owner == 2)
            chk("m_raddr", 16'(mem_endereco_leitura), 16'(lcd_endereco));
        else if (m_owner == 1 && !cpu_escrever)
            chk("m_raddr", 16'(mem_endereco_leitura), 16'(cpu_endereco_leitura));
        else if (m_owner == 0 || m_owner == 3)
            chk("m_raddr", 16'(mem_endereco_leitura), 16'd0);
        chk("m_cpu_valido", 16'(cpu_valido), 16'(m_cpu_v));
        chk("m_lcd_valido", 16'(lcd_valido), 16'(m_lcd_v));
        chk("m_cpu_dado", cpu_dado_lido, m_cpu_d);
        chk("m_lcd_dado", lcd_dado_lido, m_lcd_d);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [5];
        logic [1:0] seq_exp [5];
        int         n_oc;
        logic [15:0] orbank;
        seq_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

        // Reset with both requests high, then release: CPU wins first tie, LCD next.
        cpu_req = 1'b1; lcd_req = 1'b1; cpu_endereco_leitura = 4'd3; lcd_endereco = 4'd4;
        repeat (3) nxt();
        neg();
        chk("reset_outs", {cpu_gnt, lcd_gnt, mem_enable, cpu_valido, lcd_valido, ocupado,
                           mem_endereco_leitura, mem_endereco_escrita, 2'b00}, 16'd0);
        chk("reset_wdata", mem_conteudo_escrita, 16'd0);
        chk("reset_dados", cpu_dado_lido | lcd_dado_lido, 16'd0);
        nxt(); rst_n = 1'b1;
        nxt();
        neg();
        chk("first_gnt_cpu", {14'd0, cpu_gnt, lcd_gnt}, 16'b10);
        nxt(); cpu_req = 1'b0; lcd_req = 1'b0;
        neg();
        chk("second_gnt_lcd", {14'd0, cpu_gnt, lcd_gnt}, 16'b01);
        chk("cpu_read_valid", 16'(cpu_valido), 16'd1);
        chk("cpu_read_data", cpu_dado_lido, 16'hA003);
        nxt();
        neg();
        chk("lcd_dropped_no_valid", 16'(lcd_valido), 16'd0);

        // Contention: both held six cycles.
        nxt(); cpu_req = 1'b1; lcd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nxt();
            neg();
            seq[i] = {cpu_gnt, lcd_gnt};
        end
        nxt(); cpu_req = 1'b0; lcd_req = 1'b0;
        for (int i = 0; i < 5; i++) chk("contention_seq", 16'(seq[i]), 16'(seq_exp[i]));
        nxt();

        // CPU write BEEF to 5, then read it back.
        nxt(); cpu_req = 1'b1; cpu_escrever = 1'b1; cpu_endereco_escrita = 4'd5; cpu_dado = 16'hBEEF;
        nxt();
        neg();
        chk("wr_enable", 16'(mem_enable), 16'd1);
        chk("wr_addr", 16'(mem_endereco_escrita), 16'd5);
        chk("wr_data", mem_conteudo_escrita, 16'hBEEF);
        nxt(); cpu_escrever = 1'b0; cpu_endereco_leitura = 4'd5;
        neg();
        chk("rd_addr", 16'(mem_endereco_leitura), 16'd5);
        nxt(); cpu_req = 1'b0;
        neg();
        chk("rd_valid", 16'(cpu_valido), 16'd1);
        chk("rd_data", cpu_dado_lido, 16'hBEEF);
        nxt();
        neg();
        chk("rd_valid_pulse", 16'(cpu_valido), 16'd0);

        // Clear sweep with an LCD request raised in sweep cycle 3.
        nxt(); iniciar_clear = 1'b1; lcd_endereco = 4'd7;
        nxt(); iniciar_clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) nxt();
            if (i == 2) lcd_req = 1'b1;
            neg();
            chk("sweep_en_oc", {14'd0, mem_enable, ocupado}, 16'b11);
            chk("sweep_addr", 16'(mem_endereco_escrita), 16'(i));
            chk("sweep_data", mem_conteudo_escrita, 16'd0);
            chk("sweep_no_lcd_gnt", 16'(lcd_gnt), 16'd0);
        end
        nxt();
        neg();
        chk("after_sweep_lcd_gnt", {14'd0, lcd_gnt, ocupado}, 16'b10);
        orbank = 16'd0;
        for (int i = 0; i < 16; i++) orbank = orbank | bank[i];
        chk("bank_cleared", orbank, 16'd0);
        nxt(); lcd_req = 1'b0;
        neg();
        chk("lcd_after_sweep_data", lcd_dado_lido, 16'd0);
        nxt();

        // Clear arriving in a CPU write grant; a second clear mid-sweep is ignored.
        nxt(); cpu_req = 1'b1; cpu_escrever = 1'b1; cpu_endereco_escrita = 4'd9; cpu_dado = 16'h1234;
        nxt(); iniciar_clear = 1'b1;
        neg();
        chk("cg_write_en", 16'(mem_enable), 16'd1);
        chk("cg_write_addr", 16'(mem_endereco_escrita), 16'd9);
        chk("cg_cpu_gnt", 16'(cpu_gnt), 16'd1);
        nxt(); iniciar_clear = 1'b0; cpu_req = 1'b0;
        neg();
        chk("cg_sweep_start", {12'd0, ocupado, mem_endereco_escrita[2:0]}, 16'b1000);
        n_oc = 1;
        for (int i = 1; i < 20; i++) begin
            nxt();
            iniciar_clear = (i == 7);
            neg();
            if (ocupado) n_oc++;
        end
        chk("cg_sweep_length", 16'(n_oc), 16'd16);

        // Reset at sweep address 7 aborts; the next sweep restarts from 0.
        nxt(); iniciar_clear = 1'b1;
        nxt(); iniciar_clear = 1'b0;
        repeat (7) nxt();
        neg();
        chk("abort_addr7", 16'(mem_endereco_escrita), 16'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_enable_drop", {14'd0, mem_enable, ocupado}, 16'd0);
        nxt(); nxt(); rst_n = 1'b1;
        neg();
        chk("abort_idle", {13'd0, ocupado, cpu_gnt, lcd_gnt}, 16'd0);
        nxt(); iniciar_clear = 1'b1;
        nxt(); iniciar_clear = 1'b0;
        neg();
        chk("restart_addr0", {11'd0, ocupado, mem_endereco_escrita}, 16'h10);
        repeat (17) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
